// File: rtl/serial_adder6.sv
// serial_adder6: bit-serial 6-bit adder (IDLE/RUN/DONE FSM); optional overflow flag via OVERFLOW_FLAG_EN
module serial_adder6 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       carryIn,
    output logic [5:0] sum,
    output logic       carryOut,
    output logic       busy,
    output logic       done
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic       overflow
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     r_state;
    logic [5:0] r_a;
    logic [5:0] r_b;
    logic [4:0] r_res;
    logic       r_c;
    logic [2:0] r_cnt;
    logic       w_s;
    logic       w_co;
    assign w_s  = r_a[0] ^ r_b[0] ^ r_c;
    assign w_co = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    // At the bit-5 edge the LSBs of A/B are the original sign bits, so the
    // final sum/carry/overflow are formed directly from the live full-adder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            sum      <= '0;
            carryOut <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_c     <= carryIn;
                    r_cnt   <= '0;
                    busy    <= 1'b1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_res <= {w_s, r_res[4:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_co;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd5) begin
                        sum      <= {w_s, r_res};
                        carryOut <= w_co;
`ifdef OVERFLOW_FLAG_EN
                        overflow <= (r_a[0] == r_b[0]) && (w_s != r_a[0]);
`endif
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder6.sv
// tb_serial_adder6: model-based and directed checks for serial_adder6
module tb_serial_adder6;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       carryIn = 1'b0;
    logic [5:0] a = '0;
    logic [5:0] b = '0;
    logic [5:0] sum;
    logic       carryOut;
    logic       busy;
    logic       done;
`ifdef OVERFLOW_FLAG_EN
    logic       overflow;
`endif
    int passed = 0;
    int total = 0;

    serial_adder6 dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .carryIn(carryIn),
        .sum(sum), .carryOut(carryOut), .busy(busy), .done(done)
`ifdef OVERFLOW_FLAG_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    // Model: a job occupies 7 cycles after acceptance; the result is plain 7-bit arithmetic.
    int         m_ph = 0;
    logic [6:0] m_res = '0;
    logic [6:0] m_out = '0;
    logic       m_ovf_n = 1'b0;
    logic       m_ovf = 1'b0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = 0;
            m_out = '0;
            m_ovf = 1'b0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_ph = 1;
                m_res = {1'b0, a} + {1'b0, b} + {6'b0, carryIn};
                m_ovf_n = (a[5] == b[5]) && (m_res[5] != a[5]);
            end
        end else begin
            m_ph = (m_ph == 7) ? 0 : m_ph + 1;
            if (m_ph == 7) begin
                m_out = m_res;
                m_ovf = m_ovf_n;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, (m_ph >= 1 && m_ph <= 6));
        chk("done", done, m_ph == 7);
        chk("sum", sum, m_out[5:0]);
        chk("carryOut", carryOut, m_out[6]);
`ifdef OVERFLOW_FLAG_EN
        chk("overflow", overflow, m_ovf);
`endif
    end

    task automatic op(input logic [5:0] ta, input logic [5:0] tb, input logic tc,
                      input logic [5:0] es, input logic ec, input logic eo, input string n);
        int k;
        @(negedge clk);
        a = ta; b = tb; carryIn = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk({n, "_latency"}, k, 7);
        chk({n, "_sum"}, sum, es);
        chk({n, "_cout"}, carryOut, ec);
`ifdef OVERFLOW_FLAG_EN
        chk({n, "_ovf"}, overflow, eo);
`endif
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) nd++;
        end
    endtask

    initial begin
        int k, nd, first, last;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_sum", sum, 6'd0);
        chk("rst_cout", carryOut, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        #2 reset = 1'b0;
        op(6'b000110, 6'b000101, 1'b0, 6'b001011, 1'b0, 1'b0, "r029");
        op(6'b111100, 6'b000011, 1'b1, 6'b000000, 1'b1, 1'b0, "r030");
        op(6'b111111, 6'b111111, 1'b1, 6'b111111, 1'b1, 1'b0, "r031a");
        op(6'b011111, 6'b000001, 1'b0, 6'b100000, 1'b0, 1'b1, "r031b");
        // start pulse and operand changes during RUN are ignored
        @(negedge clk);
        a = 6'd1; b = 6'd1; carryIn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 6'b111111; b = 6'b111111; carryIn = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 6'd5; b = 6'd9;
        k = 3;
        while (!done && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk("r032_latency", k, 7);
        chk("r032_sum", sum, 6'b000010);
        count_done(12, nd);
        chk("r032_no_second", nd, 0);
        // reset on the third RUN cycle aborts the operation
        @(negedge clk);
        a = 6'd7; b = 6'd9; carryIn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("r033_busy", busy, 1'b0);
        chk("r033_done", done, 1'b0);
        chk("r033_sum", sum, 6'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        count_done(12, nd);
        chk("r033_no_done", nd, 0);
        op(6'b000010, 6'b000011, 1'b0, 6'b000101, 1'b0, 1'b0, "r033b");
        // start held high: one result every 8 cycles
        @(negedge clk);
        a = 6'd1; b = 6'd2; carryIn = 1'b0; start = 1'b1;
        nd = 0; first = 0; last = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) first = i;
                last = i;
                chk("r034_sum", sum, 6'b000011);
            end
        end
        start = 1'b0;
        chk("r034_count", nd, 2);
        chk("r034_first", first, 7);
        chk("r034_spacing", last - first, 8);
        count_done(12, nd);
        chk("r034_tail", nd, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
